converter_i2f_ext: RTL and testbench

//  Parametrised integer/fixed-point to IEEE-754 single-precision converter for the ADS1292 filter float path.

---
 rtl/converter_i2f_ext.sv | 192 +++++++++++++++++++
 tb/tb_converter_i2f_ext.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/converter_i2f_ext.sv
// Integer / fixed-point to IEEE-754 single converter with STB/ACK handshakes on both sides.
// One conversion in flight; result appears five edges after capture.
module converter_i2f_ext #(
  parameter int IN_W    = 32,
  parameter int Q_SHIFT = 0
) (
  input  logic            i_CLK,
  input  logic            i_RSTN,
  input  logic [IN_W-1:0] i_A,
  input  logic            i_SIGNED,
  input  logic [1:0]      i_RMODE,
  input  logic            i_A_STB,
  output logic            o_A_ACK,
  output logic [31:0]     o_Z,
  output logic            o_Z_STB,
  output logic            o_INEXACT,
  input  logic            i_Z_ACK
);

  localparam int EXT_W = IN_W + 26;
  localparam int LZ_W  = $clog2(IN_W + 1);

  typedef enum logic [2:0] {S_GET, S_ABS, S_NORM, S_ROUND, S_PACK, S_PUT} state_t;

  state_t state, state_nxt;
  logic   a_ack_nxt, z_stb_nxt, z_load, cap;

  logic [IN_W-1:0]          a_p0;
  logic                     sgnin_p0;
  logic [1:0]               rm_p0;
  logic                     sign_p1, zero_p1;
  logic [IN_W-1:0]          mag_p1;
  logic [1:0]               rm_p1;
  logic                     sign_p2, zero_p2, g_p2, r_p2, s_p2;
  logic [1:0]               rm_p2;
  logic [23:0]              m_p2;
  logic signed [8:0]        exp_p2;
  logic                     sign_p3, zero_p3, inex_p3;
  logic [23:0]              m_p3;
  logic signed [8:0]        exp_p3;
  logic [31:0]              z_p4;
  logic                     inex_p4;

  logic                     sign_a;
  logic [IN_W-1:0]          mag_a;
  logic [LZ_W-1:0]          lz;
  logic [IN_W-1:0]          norm;
  logic [EXT_W-1:0]         ext;
  logic signed [8:0]        exp_n;
  logic                     inc;
  logic [23:0]              m_rnd;
  logic signed [8:0]        exp_rnd;
  logic signed [8:0]        exp_b;

  function automatic logic [LZ_W-1:0] lzc(input logic [IN_W-1:0] v);
    logic [LZ_W-1:0] n;
    logic            found;
    n     = LZ_W'(IN_W);
    found = 1'b0;
    for (int i = IN_W - 1; i >= 0; i--) begin
      if (!found && v[i]) begin
        n     = LZ_W'(IN_W - 1 - i);
        found = 1'b1;
      end
    end
    return n;
  endfunction

  function automatic logic round_inc(input logic [1:0] rm, input logic sgn, input logic lsb,
                                     input logic g, input logic r, input logic s);
    logic res;
    case (rm)
      2'd0:    res = g & (r | s | lsb);
      2'd1:    res = 1'b0;
      2'd2:    res = (g | r | s) & ~sgn;
      default: res = (g | r | s) & sgn;
    endcase
    return res;
  endfunction

  always_ff @(posedge i_CLK or negedge i_RSTN) begin
    if (!i_RSTN) state <= S_GET;
    else         state <= state_nxt;
  end

  assign cap = (state == S_GET) && o_A_ACK && i_A_STB;

  always_comb begin
    state_nxt = state;
    case (state)
      S_GET:   if (o_A_ACK && i_A_STB) state_nxt = S_ABS;
      S_ABS:   state_nxt = S_NORM;
      S_NORM:  state_nxt = S_ROUND;
      S_ROUND: state_nxt = S_PACK;
      S_PACK:  state_nxt = S_PUT;
      S_PUT:   if (o_Z_STB && i_Z_ACK) state_nxt = S_GET;
      default: state_nxt = S_GET;
    endcase
  end

  // PUT spends its first cycle loading the result, so STB rises on the fifth edge
  always_comb begin
    a_ack_nxt = 1'b0;
    z_stb_nxt = 1'b0;
    z_load    = 1'b0;
    case (state)
      S_GET: a_ack_nxt = !(o_A_ACK && i_A_STB);
      S_PUT: begin
        a_ack_nxt = o_Z_STB && i_Z_ACK;
        z_stb_nxt = o_Z_STB ? !i_Z_ACK : 1'b1;
        z_load    = !o_Z_STB;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_CLK or negedge i_RSTN) begin
    if (!i_RSTN) begin
      o_A_ACK   <= 1'b0;
      o_Z_STB   <= 1'b0;
      o_Z       <= '0;
      o_INEXACT <= 1'b0;
    end else begin
      o_A_ACK <= a_ack_nxt;
      o_Z_STB <= z_stb_nxt;
      if (z_load) begin
        o_Z       <= z_p4;
        o_INEXACT <= inex_p4;
      end
    end
  end

  always_comb begin
    sign_a = sgnin_p0 & a_p0[IN_W-1];
    mag_a  = sign_a ? (~a_p0 + IN_W'(1)) : a_p0;
    lz     = lzc(mag_p1);
    norm   = mag_p1 << lz;
    ext    = {norm, 26'd0};
    exp_n  = 9'(IN_W - 1 - Q_SHIFT) - 9'(lz);
    inc    = round_inc(rm_p2, sign_p2, m_p2[0], g_p2, r_p2, s_p2);
    if (inc && (m_p2 == 24'hFFFFFF)) begin
      m_rnd   = 24'h800000;
      exp_rnd = exp_p2 + 9'sd1;
    end else begin
      m_rnd   = m_p2 + 24'(inc);
      exp_rnd = exp_p2;
    end
    exp_b = exp_p3 + 9'sd127;
  end

  always_ff @(posedge i_CLK or negedge i_RSTN) begin
    if (!i_RSTN) begin
      a_p0 <= '0; sgnin_p0 <= 1'b0; rm_p0 <= '0;
      sign_p1 <= 1'b0; zero_p1 <= 1'b0; mag_p1 <= '0; rm_p1 <= '0;
      sign_p2 <= 1'b0; zero_p2 <= 1'b0; rm_p2 <= '0; m_p2 <= '0;
      g_p2 <= 1'b0; r_p2 <= 1'b0; s_p2 <= 1'b0; exp_p2 <= '0;
      sign_p3 <= 1'b0; zero_p3 <= 1'b0; inex_p3 <= 1'b0; m_p3 <= '0; exp_p3 <= '0;
      z_p4 <= '0; inex_p4 <= 1'b0;
    end else begin
      // capture: input word held until the next accepted transfer
      if (cap) begin
        a_p0     <= i_A;
        sgnin_p0 <= i_SIGNED;
        rm_p0    <= i_RMODE;
      end
      // ABS: sign/magnitude; two's-complement negate keeps the most negative value exact
      sign_p1 <= sign_a;
      mag_p1  <= mag_a;
      zero_p1 <= (a_p0 == '0);
      rm_p1   <= rm_p0;
      // NORM: MSB aligned, 24-bit mantissa plus guard/round/sticky
      sign_p2 <= sign_p1;
      zero_p2 <= zero_p1;
      rm_p2   <= rm_p1;
      m_p2    <= ext[EXT_W-1 -: 24];
      g_p2    <= ext[EXT_W-25];
      r_p2    <= ext[EXT_W-26];
      s_p2    <= |ext[EXT_W-27:0];
      exp_p2  <= exp_n;
      // ROUND
      sign_p3 <= sign_p2;
      zero_p3 <= zero_p2;
      m_p3    <= m_rnd;
      exp_p3  <= exp_rnd;
      inex_p3 <= g_p2 | r_p2 | s_p2;
      // PACK: zero forces +0.0
      z_p4    <= zero_p3 ? 32'h0 : {sign_p3, exp_b[7:0], m_p3[22:0]};
      inex_p4 <= zero_p3 ? 1'b0 : inex_p3;
    end
  end

endmodule

// File: tb/tb_converter_i2f_ext.sv
// Directed bench for converter_i2f_ext: 32-bit integer instance and 24-bit Q23 instance.
module tb_converter_i2f_ext;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] i_A;
  logic        i_SIGNED, i_A_STB, i_Z_ACK;
  logic [1:0]  i_RMODE;
  logic        o_A_ACK, o_Z_STB, o_INEXACT;
  logic [31:0] o_Z;

  logic [23:0] b_A;
  logic        b_SIGNED, b_A_STB, b_Z_ACK;
  logic [1:0]  b_RMODE;
  logic        b_A_ACK, b_Z_STB, b_INEXACT;
  logic [31:0] b_Z;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  converter_i2f_ext #(.IN_W(32), .Q_SHIFT(0)) dut (
    .i_CLK(clk), .i_RSTN(rst_n), .i_A(i_A), .i_SIGNED(i_SIGNED), .i_RMODE(i_RMODE),
    .i_A_STB(i_A_STB), .o_A_ACK(o_A_ACK), .o_Z(o_Z), .o_Z_STB(o_Z_STB),
    .o_INEXACT(o_INEXACT), .i_Z_ACK(i_Z_ACK)
  );

  converter_i2f_ext #(.IN_W(24), .Q_SHIFT(23)) dut_q (
    .i_CLK(clk), .i_RSTN(rst_n), .i_A(b_A), .i_SIGNED(b_SIGNED), .i_RMODE(b_RMODE),
    .i_A_STB(b_A_STB), .o_A_ACK(b_A_ACK), .o_Z(b_Z), .o_Z_STB(b_Z_STB),
    .o_INEXACT(b_INEXACT), .i_Z_ACK(b_Z_ACK)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total = n_total + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic drive_capture(input logic [31:0] a, input logic sgn, input logic [1:0] rm,
                               input string tag);
    int n;
    @(negedge clk);
    i_A = a; i_SIGNED = sgn; i_RMODE = rm; i_A_STB = 1'b1;
    n = 0;
    while (o_A_ACK !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_accept"}, 64'(o_A_ACK), 64'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_result(input string tag, input logic [31:0] ez, input logic einex);
    int n;
    n = 0;
    while (o_Z_STB !== 1'b1 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({tag, "_latency"}, 64'(n), 64'd5);
    check({tag, "_z"}, 64'(o_Z), 64'(ez));
    check({tag, "_inexact"}, 64'(o_INEXACT), 64'(einex));
  endtask

  task automatic ack_result(input string tag);
    @(negedge clk);
    i_Z_ACK = 1'b1;
    @(posedge clk);
    #1;
    i_Z_ACK = 1'b0;
    check({tag, "_handshake"}, 64'({o_Z_STB, o_A_ACK}), 64'b01);
  endtask

  task automatic conv(input logic [31:0] a, input logic sgn, input logic [1:0] rm,
                      input logic [31:0] ez, input logic einex, input logic hold_ack,
                      input string tag);
    i_Z_ACK = hold_ack;
    drive_capture(a, sgn, rm, tag);
    i_A_STB = 1'b0;
    i_A = ~a;
    wait_result(tag, ez, einex);
    ack_result(tag);
  endtask

  task automatic conv_q(input logic [23:0] a, input logic sgn, input logic [31:0] ez,
                        input string tag);
    int n;
    @(negedge clk);
    b_A = a; b_SIGNED = sgn; b_RMODE = 2'd0; b_A_STB = 1'b1;
    n = 0;
    while (b_A_ACK !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    b_A_STB = 1'b0;
    b_A = ~a;
    n = 0;
    while (b_Z_STB !== 1'b1 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({tag, "_latency"}, 64'(n), 64'd5);
    check({tag, "_z"}, 64'(b_Z), 64'(ez));
    check({tag, "_inexact"}, 64'(b_INEXACT), 64'd0);
    @(negedge clk);
    b_Z_ACK = 1'b1;
    @(posedge clk);
    #1;
    b_Z_ACK = 1'b0;
    check({tag, "_handshake"}, 64'({b_Z_STB, b_A_ACK}), 64'b01);
  endtask

  initial begin
    rst_n = 1'b0;
    i_A = '0; i_SIGNED = 1'b0; i_RMODE = '0; i_A_STB = 1'b0; i_Z_ACK = 1'b0;
    b_A = '0; b_SIGNED = 1'b0; b_RMODE = '0; b_A_STB = 1'b0; b_Z_ACK = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", 64'({o_A_ACK, o_Z_STB, o_INEXACT, o_Z}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("ack_before_edge", 64'(o_A_ACK), 64'd0);
    @(posedge clk);
    #1;
    check("ack_after_edge", 64'(o_A_ACK), 64'd1);

    conv(32'h00000000, 1'b1, 2'd0, 32'h00000000, 1'b0, 1'b0, "zero");
    conv(32'hFFFFFFFF, 1'b1, 2'd0, 32'hBF800000, 1'b0, 1'b0, "minus_one");
    conv(32'h80000000, 1'b1, 2'd0, 32'hCF000000, 1'b0, 1'b0, "most_negative");
    conv(32'h00000005, 1'b1, 2'd0, 32'h40A00000, 1'b0, 1'b0, "five");
    conv(32'hFFFFFFFF, 1'b0, 2'd0, 32'h4F800000, 1'b1, 1'b0, "umax_rne");
    conv(32'hFFFFFFFF, 1'b0, 2'd1, 32'h4F7FFFFF, 1'b1, 1'b0, "umax_rtz");
    conv(32'hFFFFFFFF, 1'b0, 2'd3, 32'h4F7FFFFF, 1'b1, 1'b0, "umax_ninf");
    conv(32'hFFFFFFFF, 1'b0, 2'd2, 32'h4F800000, 1'b1, 1'b1, "umax_pinf_held_ack");
    conv(32'h01000001, 1'b0, 2'd0, 32'h4B800000, 1'b1, 1'b0, "tie_even");
    conv(32'h01000001, 1'b0, 2'd2, 32'h4B800001, 1'b1, 1'b0, "tie_pinf");
    conv(32'h01000003, 1'b0, 2'd0, 32'h4B800002, 1'b1, 1'b0, "tie_up");
    conv(32'hFEFFFFFF, 1'b1, 2'd3, 32'hCB800001, 1'b1, 1'b0, "neg_ninf");
    conv(32'hFEFFFFFF, 1'b1, 2'd2, 32'hCB800000, 1'b1, 1'b0, "neg_pinf");

    // stalled consumer while the source keeps offering a different word
    drive_capture(32'h01000003, 1'b0, 2'd0, "stall");
    i_A = 32'h12345678;
    wait_result("stall", 32'h4B800002, 1'b1);
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("stall_hold_%0d", k), 64'({o_Z_STB, o_A_ACK, o_INEXACT, o_Z}),
            64'({1'b1, 1'b0, 1'b1, 32'h4B800002}));
    end
    i_A_STB = 1'b0;
    ack_result("stall");

    // reset while the conversion sits in NORM
    drive_capture(32'hFFFFFFFF, 1'b1, 2'd0, "rst_norm");
    i_A_STB = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_norm_outputs", 64'({o_A_ACK, o_Z_STB, o_INEXACT, o_Z}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_norm_ack_low", 64'(o_A_ACK), 64'd0);
    @(posedge clk);
    #1;
    check("rst_norm_ack_high", 64'(o_A_ACK), 64'd1);
    conv(32'h00000005, 1'b1, 2'd0, 32'h40A00000, 1'b0, 1'b0, "post_reset");

    conv_q(24'h400000, 1'b1, 32'h3F000000, "q23_half");
    conv_q(24'h800000, 1'b1, 32'hBF800000, "q23_minus_one");
    conv_q(24'h800000, 1'b0, 32'h3F800000, "q23_unsigned_one");
    conv_q(24'h000001, 1'b1, 32'h34000000, "q23_lsb");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
